// File: rtl/z80_bus_master.sv
// Z80-style bus cycle generator: one request becomes a T1/T2/[TW...]/T3 memory or I/O cycle.
// Define BUS_TIMEOUT_EN to bound WAIT_L stretching to TIMEOUT_CYC wait states (err flagged).
module z80_bus_master #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int IO_WAIT     = 1,
  parameter int MEM_WAIT    = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              req,
  output logic              ready,
  input  logic              req_we,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic              WAIT_L,
  output logic [ADDR_W-1:0] addr_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              MREQ_L,
  output logic              IORQ_L,
  output logic              RD_L,
  output logic              WR_L
);

  // Handshake: a request transfers on a posedge where req && ready; ready is high
  // only in IDLE (including the done cycle), so req in any other state is ignored.
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              io_q, io_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              strobe_act;
  logic              bus_act;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] stretch_q, stretch_d;
  logic            to_q, to_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      io_q    <= io_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      stretch_q <= '0;
      to_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stretch_q <= stretch_d;
      to_q      <= to_d;
      err_q     <= err_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    io_d    = io_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
`ifdef BUS_TIMEOUT_EN
    stretch_d = stretch_q;
    to_d      = to_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = req_we;
          io_d    = req_io;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_T1;
        end
      end
      S_T1: begin
        state_d = S_T2;
        wcnt_d  = io_q ? 3'(IO_WAIT) : 3'(MEM_WAIT);
`ifdef BUS_TIMEOUT_EN
        stretch_d = '0;
        to_d      = 1'b0;
`endif
      end
      S_T2, S_TW: begin
        // Auto waits take priority; WAIT_L is only consulted once they are used up.
        if (wcnt_q != 3'd0) begin
          state_d = S_TW;
          wcnt_d  = wcnt_q - 3'd1;
`ifdef BUS_TIMEOUT_EN
        end else if (stretch_q == TO_W'(TIMEOUT_CYC)) begin
          state_d = S_T3;
          to_d    = 1'b1;
`endif
        end else if (!WAIT_L) begin
          state_d = S_TW;
`ifdef BUS_TIMEOUT_EN
          stretch_d = stretch_q + 1'b1;
`endif
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!we_q) rdata_d = data_bus;
`ifdef BUS_TIMEOUT_EN
        if (to_q) begin
          err_d = 1'b1;
          if (!we_q) rdata_d = '1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset releases them at once.
  assign strobe_act = (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);
  assign bus_act    = (state_q != S_IDLE);

  assign ready    = (state_q == S_IDLE);
  assign MREQ_L   = ~(strobe_act && !io_q);
  assign IORQ_L   = ~(strobe_act && io_q);
  assign RD_L     = ~(strobe_act && !we_q);
  assign WR_L     = ~(strobe_act && we_q);
  assign addr_bus = bus_act ? addr_q : 'z;
  assign data_bus = (bus_act && we_q) ? wdata_q : 'z;
  assign done     = done_q;
  assign rdata    = rdata_q;
`ifdef BUS_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: randomized and directed bus cycles against a cycle-count model.
module tb_z80_bus_master;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int IO_WAIT     = 1;
  localparam int MEM_WAIT    = 0;
  localparam int TIMEOUT_CYC = 4;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              req = 1'b0;
  logic              req_we = 1'b0;
  logic              req_io = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              WAIT_L = 1'b1;
  logic [DATA_W-1:0] periph_data = '0;
  wire               ready, done, err;
  wire  [DATA_W-1:0] rdata;
  wire               MREQ_L, IORQ_L, RD_L, WR_L;
  wire  [ADDR_W-1:0] addr_bus;
  wire  [DATA_W-1:0] data_bus;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_rdata = '0;

  // Peripheral answers reads while RD_L is low; released buses float high.
  assign data_bus = (!RD_L) ? periph_data : 'z;
  pullup (data_bus);
  pullup (addr_bus);

  z80_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IO_WAIT(IO_WAIT),
    .MEM_WAIT(MEM_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset_L(reset_L), .req(req), .ready(ready),
    .req_we(req_we), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .rdata(rdata), .err(err), .WAIT_L(WAIT_L),
    .addr_bus(addr_bus), .data_bus(data_bus),
    .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: cycle holds WAIT_L low for nlow samples starting at the end of T2.
  function automatic int model_stretch(input int nlow, input int auto_w);
    int s;
    s = nlow - auto_w;
    if (s < 0) s = 0;
`ifdef BUS_TIMEOUT_EN
    if (s > TIMEOUT_CYC) s = TIMEOUT_CYC;
`endif
    return s;
  endfunction

  function automatic bit model_err(input int nlow, input int auto_w);
`ifdef BUS_TIMEOUT_EN
    return (nlow - auto_w) >= TIMEOUT_CYC;
`else
    return 1'b0;
`endif
  endfunction

  // Called and returns at a negedge; hold keeps req high with junk fields while busy.
  task automatic do_txn(input logic we, input logic io, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] pdata,
                        input int nlow, input bit hold);
    int auto_w, len, done_at;
    int mreq_low, iorq_low, rd_low, wr_low, busy_flags, addr_bad, data_bad;
    bit exp_err, err_seen;
    logic [DATA_W-1:0] rdata_seen, exp_d, exp_r;
    logic [ADDR_W-1:0] exp_a;
    auto_w = io ? IO_WAIT : MEM_WAIT;
    len = 3 + auto_w + model_stretch(nlow, auto_w);
    exp_err = model_err(nlow, auto_w);
    if (!we) model_rdata = exp_err ? {DATA_W{1'b1}} : pdata;
    exp_q.push_back(model_rdata);
    {mreq_low, iorq_low, rd_low, wr_low, busy_flags, addr_bad, data_bad} = '0;
    done_at = 0; err_seen = 1'b0; rdata_seen = '0;
    periph_data = pdata;
    WAIT_L = 1'b1;
    req = 1'b1; req_we = we; req_io = io; req_addr = addr; req_wdata = wdata;
    check_eq("ready_idle", ready, 1);
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c <= len && (ready || done)) busy_flags++;
      if (!MREQ_L) mreq_low++;
      if (!IORQ_L) iorq_low++;
      if (!RD_L) rd_low++;
      if (!WR_L) wr_low++;
      exp_a = (c <= len) ? addr : {ADDR_W{1'b1}};
      if (addr_bus !== exp_a) addr_bad++;
      if (c <= len && we) exp_d = wdata;
      else if (c >= 2 && c <= len && !we) exp_d = pdata;
      else exp_d = {DATA_W{1'b1}};
      if (data_bus !== exp_d) data_bad++;
      if (done) begin
        done_at = c; err_seen = err; rdata_seen = rdata;
        break;
      end
      WAIT_L = !(c >= 2 && c <= nlow + 1);
      if (hold) begin
        req_we = 1'($urandom); req_io = 1'($urandom);
        req_addr = ADDR_W'($urandom); req_wdata = DATA_W'($urandom);
      end else begin
        req = 1'b0;
      end
    end
    WAIT_L = 1'b1;
    if (!hold) req = 1'b0;
    if (done_at == 0) check_eq("done_seen", 0, 1);
    check_eq("done_latency", done_at, len + 1);
    check_eq("mreq_low_cycles", mreq_low, io ? 0 : len - 1);
    check_eq("iorq_low_cycles", iorq_low, io ? len - 1 : 0);
    check_eq("rd_low_cycles", rd_low, we ? 0 : len - 1);
    check_eq("wr_low_cycles", wr_low, we ? len - 1 : 0);
    check_eq("busy_ready_or_done", busy_flags, 0);
    check_eq("addr_bus_cycles_bad", addr_bad, 0);
    check_eq("data_bus_cycles_bad", data_bad, 0);
    check_eq("err", err_seen, exp_err);
    exp_r = exp_q.pop_front();
    check_eq("rdata", rdata_seen, exp_r);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_strobes", {MREQ_L, IORQ_L, RD_L, WR_L}, 4'hF);
    check_eq("rst_addr_z", addr_bus, 16'hFFFF);
    check_eq("rst_data_z", data_bus, 8'hFF);
    reset_L = 1'b1;
    @(negedge clk);

    do_txn(1'b1, 1'b1, 16'h00BE, 8'hDD, 8'h00, 0, 1'b0);
    do_txn(1'b0, 1'b1, 16'h00BF, 8'h21, 8'h5A, 0, 1'b0);
    do_txn(1'b0, 1'b0, 16'h8123, 8'h42, 8'hC3, 5, 1'b0);
    do_txn(1'b1, 1'b0, 16'h4000, 8'h77, 8'h00, 0, 1'b1);
    do_txn(1'b0, 1'b1, 16'h0099, 8'h11, 8'h96, 2, 1'b1);
    do_txn(1'b0, 1'b0, 16'h0001, 8'h10, 8'h3E, 0, 1'b0);

    // Async reset in the middle of a write's TW state.
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_io = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
    @(posedge clk);
    @(negedge clk); req = 1'b0; WAIT_L = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_reset_iorq", IORQ_L, 0);
    #1 reset_L = 1'b0;
    #1;
    check_eq("mid_rst_strobes", {MREQ_L, IORQ_L, RD_L, WR_L}, 4'hF);
    check_eq("mid_rst_addr_z", addr_bus, 16'hFFFF);
    check_eq("mid_rst_data_z", data_bus, 8'hFF);
    check_eq("mid_rst_ready", ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_done", done, 0);
    end
    check_eq("mid_rst_rdata", rdata, 0);
    reset_L = 1'b1; WAIT_L = 1'b1;
    model_rdata = '0;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 16'hBEEF, 8'h5C, 8'h00, 1, 1'b0);

    // WAIT_L stuck low on an I/O read: bounded only when the timeout is built in.
    do_txn(1'b0, 1'b1, 16'h00BF, 8'h00, 8'h3C, 100, 1'b0);
    do_txn(1'b1, 1'b1, 16'h00C0, 8'h81, 8'h00, 100, 1'b0);

    for (int t = 0; t < 24; t++) begin
      do_txn(1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
             DATA_W'($urandom), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req = 1'b0;
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("final_idle_ready", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
